bit_serial_adder: RTL and testbench

- Bit-serial adder: the addition counterpart of the single-bit borrow-ripple full-subtractor cell.
- Accepts two WIDTH-bit operands and a carry-in on a start strobe.
- Adds one bit per clock, LSB first, through a single full-adder cell and a registered carry.
- Returns the WIDTH-bit sum and carry-out with a one-cycle done pulse. Used where area matters more than latency in the arithmetic datapath.

---
 rtl/bit_serial_adder_pkg.sv | 16 +
 rtl/bit_serial_adder_full_adder_cell.sv | 17 +
 rtl/bit_serial_adder.sv | 122 ++++++++++++
 tb/tb_bit_serial_adder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// the helper that sizes the bit counter from the operand width.
package bit_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Bit-counter width for a given operand width; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/bit_serial_adder_full_adder_cell.sv
// Single-bit full-adder cell; the additive twin of the borrow-ripple
// subtractor cell. Purely combinational.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    logic half_s;

    assign half_s = a ^ b;
    assign s      = half_s ^ c;
    assign co     = (a & b) | (c & half_s);

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: captures two operands and a carry-in on start, adds one
// bit per clock LSB-first through one full-adder cell, then publishes the
// sum and carry-out together with a one-cycle done pulse.
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state_r;
    logic [WIDTH-1:0]   a_sh_r;
    logic [WIDTH-1:0]   b_sh_r;
    // Holds the sum bits produced so far; the bit being computed this cycle
    // comes straight from the cell, so only WIDTH-1 bits need storage.
    logic [WIDTH-2:0]   s_sh_r;
    logic               carry_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   sum_r;
    logic               cout_r;
    logic               done_r;

    logic               fa_sum_s;
    logic               fa_cout_s;
    logic [WIDTH-1:0]   sum_next_s;

    full_adder_cell u_fa (
        .a  (a_sh_r[0]),
        .b  (b_sh_r[0]),
        .c  (carry_r),
        .s  (fa_sum_s),
        .co (fa_cout_s)
    );

    // New sum bit enters at the top; after the last bit this is the full result.
    assign sum_next_s = {fa_sum_s, s_sh_r};

    // Sequencer: operand load, per-bit shift/carry update and result publication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            a_sh_r  <= {WIDTH{1'b0}};
            b_sh_r  <= {WIDTH{1'b0}};
            s_sh_r  <= {(WIDTH-1){1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            sum_r   <= {WIDTH{1'b0}};
            cout_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_sh_r  <= a;
                        b_sh_r  <= b;
                        s_sh_r  <= {(WIDTH-1){1'b0}};
                        carry_r <= cin;
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    // start is deliberately not looked at here: in-flight work is never disturbed.
                    a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
                    s_sh_r  <= sum_next_s[WIDTH-1:1];
                    carry_r <= fa_cout_s;
                    cnt_r   <= cnt_r + CNT_W'(1);
                    if (cnt_r == LAST_CNT) begin
                        sum_r   <= sum_next_s;
                        cout_r  <= fa_cout_s;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        done_r  <= 1'b0;
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    // Restart straight from DONE so back-to-back adds lose no cycle.
                    if (start) begin
                        a_sh_r  <= a;
                        b_sh_r  <= b;
                        s_sh_r  <= {(WIDTH-1){1'b0}};
                        carry_r <= cin;
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state_r == RUN);
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed bench for bit_serial_adder: an 8-bit instance for the main
// scenarios and a 4-bit instance for an exhaustive operand sweep.
module tb_bit_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       cin4;
    logic       busy4;
    logic       done4;
    logic [3:0] sum4;
    logic       cout4;

    int errors;
    int checks;

    bit_serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    bit_serial_adder #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Runs one 8-bit add starting at a negedge. Returns the number of negedges
    // from the start edge to the done cycle, the cycles busy was seen high and
    // how often sum/cout moved away from the previous result before done.
    // If inject_at > 0, a junk start is driven at that RUN cycle.
    task automatic run_add(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                           input int inject_at, input logic [7:0] hold_sum, input logic hold_cout,
                           output int lat, output int busy_hi, output int hold_bad);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1; busy_hi = 0; hold_bad = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_hi++;
            if (sum !== hold_sum || cout !== hold_cout) hold_bad++;
            if (lat == inject_at) begin
                start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
        start4 = 1'b0; a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl: busy=%b done=%b, required 0 0", busy, done);
        end
        checks++;
        if (sum !== 8'h00 || cout !== 1'b0) begin
            errors++; $display("FAIL reset_data: sum=%h cout=%b, required 00 0", sum, cout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_release: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_basic;
        int lat, bh, hb;
        run_add(8'h35, 8'h4A, 1'b0, 0, 8'h00, 1'b0, lat, bh, hb);
        checks++;
        if (lat !== 9) begin
            errors++; $display("FAIL basic_latency: negedges=%0d, required 9", lat);
        end
        checks++;
        if (bh !== 8) begin
            errors++; $display("FAIL basic_busy: busy cycles=%0d, required 8", bh);
        end
        checks++;
        if (sum !== 8'h7F || cout !== 1'b0) begin
            errors++; $display("FAIL basic_result: sum=%h cout=%b, required 7f 0", sum, cout);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || sum !== 8'h7F) begin
            errors++; $display("FAIL basic_pulse: done=%b busy=%b sum=%h, required 0 0 7f", done, busy, sum);
        end
    endtask

    task automatic test_vectors;
        logic [7:0] va [3];
        logic [7:0] vb [3];
        logic       vc [3];
        logic [7:0] es [3];
        logic       ec [3];
        logic [7:0] ps;
        logic       pc;
        int lat, bh, hb;
        va = '{8'hFF, 8'hFF, 8'h00};
        vb = '{8'h01, 8'hFF, 8'h00};
        vc = '{1'b0, 1'b1, 1'b1};
        es = '{8'h00, 8'hFF, 8'h01};
        ec = '{1'b1, 1'b1, 1'b0};
        ps = 8'h7F; pc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run_add(va[i], vb[i], vc[i], 0, ps, pc, lat, bh, hb);
            checks++;
            if (sum !== es[i] || cout !== ec[i] || lat !== 9) begin
                errors++;
                $display("FAIL vec%0d: sum=%h cout=%b lat=%0d, required %h %b 9", i, sum, cout, lat, es[i], ec[i]);
            end
            checks++;
            if (hb !== 0) begin
                errors++; $display("FAIL vec%0d_hold: changed cycles=%0d, required 0", i, hb);
            end
            ps = es[i]; pc = ec[i];
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_start;
        int lat, bh, hb;
        run_add(8'h12, 8'h34, 1'b0, 3, 8'h01, 1'b0, lat, bh, hb);
        checks++;
        if (sum !== 8'h46 || cout !== 1'b0 || lat !== 9 || hb !== 0) begin
            errors++;
            $display("FAIL ignore_start: sum=%h cout=%b lat=%0d hold=%0d, required 46 0 9 0", sum, cout, lat, hb);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL ignore_idle: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back;
        int lat, bh, hb, n;
        run_add(8'h80, 8'h80, 1'b1, 0, 8'h46, 1'b0, lat, bh, hb);
        checks++;
        if (sum !== 8'h01 || cout !== 1'b1 || lat !== 9) begin
            errors++; $display("FAIL b2b_first: sum=%h cout=%b lat=%0d, required 01 1 9", sum, cout, lat);
        end
        // Still in the done cycle: request the next add right away.
        a = 8'h3C; b = 8'h0F; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL b2b_nogap: busy=%b, required 1", busy);
        end
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 9 || sum !== 8'h4B || cout !== 1'b0) begin
            errors++; $display("FAIL b2b_second: gap=%0d sum=%h cout=%b, required 9 4b 0", n, sum, cout);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run;
        int seen_done, lat, bh, hb;
        a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
            errors++;
            $display("FAIL midrun_async: busy=%b done=%b sum=%h cout=%b, required 0 0 00 0", busy, done, sum, cout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        checks++;
        if (seen_done !== 0) begin
            errors++; $display("FAIL midrun_nodone: active cycles=%0d, required 0", seen_done);
        end
        run_add(8'hC3, 8'h3C, 1'b1, 0, 8'h00, 1'b0, lat, bh, hb);
        checks++;
        if (sum !== 8'h00 || cout !== 1'b1 || lat !== 9 || hb !== 0) begin
            errors++;
            $display("FAIL midrun_fresh: sum=%h cout=%b lat=%0d hold=%0d, required 00 1 9 0", sum, cout, lat, hb);
        end
        @(negedge clk);
    endtask

    task automatic test_w4_sweep;
        int n;
        logic [4:0] exp_v;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                for (int k = 0; k < 2; k++) begin
                    exp_v = 5'(i + j + k);
                    a4 = 4'(i); b4 = 4'(j); cin4 = k[0]; start4 = 1'b1;
                    @(negedge clk);
                    start4 = 1'b0;
                    n = 1;
                    while (done4 !== 1'b1 && n < 20) begin
                        @(negedge clk);
                        n++;
                    end
                    checks++;
                    if ({cout4, sum4} !== exp_v || n !== 5) begin
                        errors++;
                        $display("FAIL w4 a=%h b=%h cin=%0d: got %b lat=%0d, required %b 5", i[3:0], j[3:0], k, {cout4, sum4}, n, exp_v);
                    end
                    @(negedge clk);
                end
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic();
        test_vectors();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_w4_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
